mux_with_default: RTL and testbench
===================================

# mux_with_default

Parameterised key-lookup multiplexer with a default value. It compares a key against a packed table of (key, data) pairs and returns the data of the matching entry, or a supplied default when no entry matches. The core datapath provides the lookup combinationally, for example to gate instruction-ROM data with a read enable. A registered copy and status flags are also provided on the core clock for pipelined consumers.

## Interface
- `NR_KEY`, default 2: number of (key, data) entries in the table; must be ≥1.
- `KEY_LEN`, default 1: width of each key in bits.
- `DATA_LEN`, default 32: width of each data word and of the default.
- `clk`  in  1: core clock; all registers are rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `out`  out  DATA_LEN: combinational lookup result.
- `key`  in  KEY_LEN: lookup key.
- `default_out`  in  DATA_LEN: value driven on `out` when no entry matches.
- `lut`  in  NR_KEY*(KEY_LEN+DATA_LEN): packed table. Entry i occupies bits [(i+1)*P-1 : i*P], where P = KEY_LEN+DATA_LEN. Within an entry, the key is in the upper KEY_LEN bits and the data is in the lower DATA_LEN bits. Entry 0 is at the LSB end.
- `hit`  out  1: combinational; 1 when at least one entry key equals `key`.
- `multi_hit`  out  1: combinational; 1 when two or more entry keys equal `key`.
- `out_q`  out  DATA_LEN: `out` registered.
- `hit_q`  out  1: `hit` registered.
- `multi_hit_err`  out  1: sticky error flag, set when `multi_hit` is sampled high.

## Operation
- Decode entries: key_i = lut[i*P+P-1 : i*P+DATA_LEN]; data_i = lut[i*P+DATA_LEN-1 : i*P].
- match_i = (key_i == key), a full KEY_LEN-bit equality compare.
- `hit` = OR of all match_i.
- `multi_hit` = 1 when the popcount of match_i is ≥2.
- `out` = data_j, where j is the lowest index with match_j = 1. When no entry matches, `out` = `default_out`.
- Duplicate keys are legal: the lowest index wins and `multi_hit` flags the condition.
- `out`, `hit` and `multi_hit` are purely combinational with no dependency on `clk` or `rst_n`. They are valid within the same cycle the inputs change.
- X or unknown on `key` must not be masked by the default; simulation may propagate X.
- The `lut` width is fixed by the parameters; no width truncation or extension occurs.

## Timing
- Combinational outputs: zero-cycle latency.
- `out_q` and `hit_q` update on every rising edge of `clk` with the current `out` and `hit`. They have one-cycle latency and no enable.
- `multi_hit_err` sets on a rising edge where `multi_hit` = 1. It stays at 1 until reset.
- `rst_n` low, asynchronously and regardless of `clk`, forces:
  - `out_q` = 0
  - `hit_q` = 0
  - `multi_hit_err` = 0
- Reset asserted mid-operation clears the registers immediately. Combinational outputs remain driven by their inputs during reset.
- Registers resume capturing on the first rising edge after `rst_n` deasserts.

## Test plan
- NR_KEY=2, KEY_LEN=1, DATA_LEN=32, lut = {1'b0, 32'h0, 1'b1, 32'hDEADBEEF}, default 0. Both keys must be checked:
  - key=1 -> `out` = 32'hDEADBEEF, `hit` = 1, `multi_hit` = 0.
  - key=0 -> `out` = 0, `hit` = 1.
- No match: NR_KEY=2, KEY_LEN=2, keys 2'b01 and 2'b10, default 32'hCAFE0000, key=2'b11 -> `out` = 32'hCAFE0000, `hit` = 0.
- Duplicate keys: entry0 = (1, 32'h11), entry1 = (1, 32'h22), key=1 -> `out` = 32'h11, `multi_hit` = 1. After one clock, `multi_hit_err` = 1 and it remains 1 after the key changes.
- Registered path: key=1 on cycle n (table as in the first scenario) -> `out_q` = 32'hDEADBEEF and `hit_q` = 1 after the edge ending cycle n. They must not change before that edge.
- Async reset: drive `rst_n` low between clock edges while `out_q` is nonzero and `multi_hit_err` = 1:
  - Registers must clear to 0 immediately, without a clock edge.
  - `out` must still track the inputs.
  - After `rst_n` rises, the next edge reloads `out_q`.
- Sweep: NR_KEY=4, KEY_LEN=2, unique keys 0-3 with data 10, 20, 30, 40, all four keys applied -> `out` = 10, 20, 30, 40 respectively, `hit` = 1, `multi_hit` = 0.

Source files
------------

// File: rtl/mux_with_default.sv
// Key-lookup mux: lowest matching table entry wins, else default_out.
// Registered copies of the result plus a sticky duplicate-key flag.
module mux_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic [DATA_LEN-1:0]                   out,
  input  logic [KEY_LEN-1:0]                    key,
  input  logic [DATA_LEN-1:0]                   default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]  lut,
  output logic                                  hit,
  output logic                                  multi_hit,
  output logic [DATA_LEN-1:0]                   out_q,
  output logic                                  hit_q,
  output logic                                  multi_hit_err
);

  localparam int P = KEY_LEN + DATA_LEN;

  logic [NR_KEY-1:0]   match;
  logic [NR_KEY-1:0]   first;
  logic [DATA_LEN-1:0] sel;
  logic                seen;
  logic                dup;

  // AND-OR select keeps an unknown key visible instead of masking it
  always_comb begin
    match = '0;
    first = '0;
    sel   = '0;
    seen  = 1'b0;
    dup   = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i] = (lut[i*P+DATA_LEN +: KEY_LEN] == key);
      first[i] = match[i] & ~seen;
      dup      = dup | (match[i] & seen);
      seen     = seen | match[i];
      sel      = sel | (lut[i*P +: DATA_LEN] & {DATA_LEN{first[i]}});
    end
  end

  assign hit       = seen;
  assign multi_hit = dup;
  assign out       = sel | (default_out & {DATA_LEN{~seen}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= '0;
      hit_q         <= 1'b0;
      multi_hit_err <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
      if (multi_hit)
        multi_hit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_with_default.sv
// Randomised and directed bench for mux_with_default.
// Two instances: 2x1-bit keys and 4x2-bit keys, 32-bit data.
module tb_mux_with_default;

  typedef logic [1:0]  k_arr_t [4];
  typedef logic [31:0] d_arr_t [4];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // instance A: NR_KEY=2, KEY_LEN=1
  k_arr_t      ka;
  d_arr_t      da;
  logic        a_key;
  logic [31:0] a_def;
  logic [65:0] a_lut;
  logic [31:0] a_out, a_out_q;
  logic        a_hit, a_multi, a_hit_q, a_err;

  // instance B: NR_KEY=4, KEY_LEN=2
  k_arr_t       kb;
  d_arr_t       db;
  logic [1:0]   b_key;
  logic [31:0]  b_def;
  logic [135:0] b_lut;
  logic [31:0]  b_out, b_out_q;
  logic         b_hit, b_multi, b_hit_q, b_err;

  assign a_lut = {ka[1][0], da[1], ka[0][0], da[0]};

  always_comb begin
    b_lut = '0;
    for (int i = 0; i < 4; i++)
      b_lut[i*34 +: 34] = {kb[i], db[i]};
  end

  mux_with_default #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) u_a (
    .clk(clk), .rst_n(rst_n), .out(a_out), .key(a_key),
    .default_out(a_def), .lut(a_lut), .hit(a_hit),
    .multi_hit(a_multi), .out_q(a_out_q), .hit_q(a_hit_q),
    .multi_hit_err(a_err)
  );

  mux_with_default #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(32)) u_b (
    .clk(clk), .rst_n(rst_n), .out(b_out), .key(b_key),
    .default_out(b_def), .lut(b_lut), .hit(b_hit),
    .multi_hit(b_multi), .out_q(b_out_q), .hit_q(b_hit_q),
    .multi_hit_err(b_err)
  );

  // count matches; the first one found supplies the data
  function automatic void ref_lookup(
    input int n, input k_arr_t k, input d_arr_t d,
    input logic [1:0] kv, input logic [31:0] def,
    output logic [31:0] o, output logic h, output logic m);
    int cnt;
    cnt = 0;
    o   = def;
    for (int i = 0; i < n; i++) begin
      if (k[i] == kv) begin
        if (cnt == 0) o = d[i];
        cnt++;
      end
    end
    h = (cnt > 0);
    m = (cnt > 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // expected register state
  logic [31:0] ea_q = '0, eb_q = '0;
  logic        ea_h = 1'b0, eb_h = 1'b0;
  logic        ea_e = 1'b0, eb_e = 1'b0;

  always @(posedge clk) begin
    logic [31:0] o;
    logic        h, m;
    if (rst_n) begin
      ref_lookup(2, ka, da, {1'b0, a_key}, a_def, o, h, m);
      ea_q = o; ea_h = h;
      if (m) ea_e = 1'b1;
      ref_lookup(4, kb, db, b_key, b_def, o, h, m);
      eb_q = o; eb_h = h;
      if (m) eb_e = 1'b1;
    end
  end

  always @(negedge rst_n) begin
    ea_q = '0; ea_h = 1'b0; ea_e = 1'b0;
    eb_q = '0; eb_h = 1'b0; eb_e = 1'b0;
  end

  always @(negedge clk) begin
    logic [31:0] o;
    logic        h, m;
    ref_lookup(2, ka, da, {1'b0, a_key}, a_def, o, h, m);
    chk("a_out", a_out, o);
    chk("a_hit", {31'b0, a_hit}, {31'b0, h});
    chk("a_multi", {31'b0, a_multi}, {31'b0, m});
    chk("a_out_q", a_out_q, ea_q);
    chk("a_hit_q", {31'b0, a_hit_q}, {31'b0, ea_h});
    chk("a_err", {31'b0, a_err}, {31'b0, ea_e});
    ref_lookup(4, kb, db, b_key, b_def, o, h, m);
    chk("b_out", b_out, o);
    chk("b_hit", {31'b0, b_hit}, {31'b0, h});
    chk("b_multi", {31'b0, b_multi}, {31'b0, m});
    chk("b_out_q", b_out_q, eb_q);
    chk("b_hit_q", {31'b0, b_hit_q}, {31'b0, eb_h});
    chk("b_err", {31'b0, b_err}, {31'b0, eb_e});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_base();
    ka[0] = 2'd1; da[0] = 32'hDEADBEEF;
    ka[1] = 2'd0; da[1] = 32'h0;
    ka[2] = 2'd0; da[2] = 32'h0;
    ka[3] = 2'd0; da[3] = 32'h0;
    a_def = 32'h0;
  endtask

  initial begin
    set_a_base();
    a_key = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kb[i] = 2'(i);
      db[i] = 32'(10 * (i + 1));
    end
    b_key = 2'd0;
    b_def = 32'h0;

    #1;
    chk("rst_out_q", a_out_q, 32'h0);
    chk("rst_hit_q", {31'b0, a_hit_q}, 32'h0);
    chk("rst_err", {31'b0, a_err}, 32'h0);
    #11 rst_n = 1'b1;

    // basic table, both keys
    step();
    a_key = 1'b1; #1;
    chk("k1_out", a_out, 32'hDEADBEEF);
    chk("k1_hit", {31'b0, a_hit}, 32'h1);
    chk("k1_multi", {31'b0, a_multi}, 32'h0);
    a_key = 1'b0; #1;
    chk("k0_out", a_out, 32'h0);
    chk("k0_hit", {31'b0, a_hit}, 32'h1);

    // registered path holds until the edge
    step();
    a_key = 1'b1; #1;
    chk("reg_hold", a_out_q, 32'h0);
    step();
    chk("reg_out_q", a_out_q, 32'hDEADBEEF);
    chk("reg_hit_q", {31'b0, a_hit_q}, 32'h1);

    // no match on B
    kb[0] = 2'b01; kb[1] = 2'b10; kb[2] = 2'b01; kb[3] = 2'b10;
    b_def = 32'hCAFE0000;
    b_key = 2'b11; #1;
    chk("nm_out", b_out, 32'hCAFE0000);
    chk("nm_hit", {31'b0, b_hit}, 32'h0);

    // sweep unique keys
    for (int i = 0; i < 4; i++) begin
      kb[i] = 2'(i);
      db[i] = 32'(10 * (i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      b_key = 2'(i); #1;
      chk("sw_out", b_out, 32'(10 * (i + 1)));
      chk("sw_hit", {31'b0, b_hit}, 32'h1);
      chk("sw_multi", {31'b0, b_multi}, 32'h0);
    end

    // duplicate keys
    step();
    ka[0] = 2'd1; da[0] = 32'h11;
    ka[1] = 2'd1; da[1] = 32'h22;
    a_key = 1'b1; #1;
    chk("dup_out", a_out, 32'h11);
    chk("dup_multi", {31'b0, a_multi}, 32'h1);
    step();
    chk("dup_err", {31'b0, a_err}, 32'h1);
    a_key = 1'b0;
    step();
    chk("dup_sticky", {31'b0, a_err}, 32'h1);

    // async reset mid-cycle
    set_a_base();
    a_key = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_q", a_out_q, 32'h0);
    chk("ar_hit_q", {31'b0, a_hit_q}, 32'h0);
    chk("ar_err", {31'b0, a_err}, 32'h0);
    chk("ar_out", a_out, 32'hDEADBEEF);
    a_key = 1'b0; #1;
    chk("ar_track", a_out, 32'h0);
    a_key = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ar_reload", a_out_q, 32'hDEADBEEF);

    // random traffic with occasional reset pulses
    repeat (400) begin
      step();
      for (int i = 0; i < 2; i++) begin
        ka[i] = 2'($urandom_range(0, 1));
        da[i] = $urandom;
      end
      for (int i = 0; i < 4; i++) begin
        kb[i] = 2'($urandom_range(0, 3));
        db[i] = $urandom;
      end
      a_key = 1'($urandom_range(0, 1));
      b_key = 2'($urandom_range(0, 3));
      a_def = $urandom;
      b_def = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
